// File: rtl/fetch_pkg.sv
// Shared types for the fetch program counter: FSM state and redirect cause encodings.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    NONE     = 3'd0,
    TRAP     = 3'd1,
    MISALIGN = 3'd2,
    BRANCH   = 3'd3,
    RET      = 3'd4
  } cause_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack as a circular buffer; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RAS_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [ADDR_WIDTH-1:0]        i_push_addr,
  output logic [ADDR_WIDTH-1:0]        o_top_addr,
  output logic [$clog2(RAS_DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PTR_W-1:0]      r_top;
  logic [CNT_W-1:0]      r_count;
  logic [PTR_W-1:0]      w_next_top;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop_ok;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(RAS_DEPTH));
  assign w_pop_ok   = i_pop && !w_empty;
  assign w_next_top = r_top + 1'b1;

  assign o_top_addr = r_mem[r_top];
  assign o_count    = r_count;

  // Simultaneous push and pop replaces the top entry in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_top   <= '1;
      r_count <= '0;
    end else if (i_push && !w_pop_ok) begin
      r_top <= w_next_top;
      if (!w_full) begin
        r_count <= r_count + 1'b1;
      end
    end else if (w_pop_ok && !i_push) begin
      r_top   <= r_top - 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      if (w_pop_ok) begin
        r_mem[r_top] <= i_push_addr;
      end else begin
        r_mem[w_next_top] <= i_push_addr;
      end
    end
  end

endmodule

// File: rtl/fetch_pc.sv
// Fetch program counter: sequential advance, prioritised redirects, trap bubble and a return-address stack.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR  = '0,
  parameter int unsigned           INSTR_BYTES = 4,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = 'h100,
  parameter int unsigned           RAS_DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [ADDR_WIDTH-1:0]      fetch_addr,
  output logic                       fetch_valid,
  input  logic                       fetch_ready,
  input  logic                       branch_taken,
  input  logic [ADDR_WIDTH-1:0]      branch_target,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       trap,
  output logic                       misaligned,
  output logic                       ras_underflow,
  output logic [$clog2(RAS_DEPTH):0] ras_count
);

  localparam int unsigned           CNT_W      = $clog2(RAS_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(INSTR_BYTES);

  state_e                r_state;
  state_e                w_state_next;
  cause_e                w_cause;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic [ADDR_WIDTH-1:0] w_seq_pc;
  logic [ADDR_WIDTH-1:0] w_ras_top;
  logic [CNT_W-1:0]      w_ras_count;
  logic                  w_run;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_underflow;
  logic                  r_misaligned;
  logic                  r_ras_underflow;

  assign w_run    = (r_state == RUN);
  assign w_accept = w_run && fetch_ready;
  assign w_seq_pc = r_pc + STEP;

  // Trap is honoured in every state; all other redirects only while running.
  always_comb begin
    w_cause = NONE;
    if (trap) begin
      w_cause = TRAP;
    end else if (w_run) begin
      if (branch_taken && ((branch_target & ALIGN_MASK) != '0)) begin
        w_cause = MISALIGN;
      end else if (branch_taken) begin
        w_cause = BRANCH;
      end else if (ret && (w_ras_count != '0)) begin
        w_cause = RET;
      end
    end
  end

  // Calls push their return address even when a branch redirects the same cycle.
  assign w_push      = w_accept && call && !trap;
  assign w_pop       = (w_cause == RET);
  assign w_underflow = w_run && ret && (w_ras_count == '0) && !trap && !branch_taken;

  always_comb begin
    w_pc_next = r_pc;
    case (w_cause)
      TRAP, MISALIGN: w_pc_next = TRAP_VECTOR;
      BRANCH:         w_pc_next = branch_target;
      RET:            w_pc_next = w_ras_top;
      default:        w_pc_next = w_accept ? w_seq_pc : r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BOOT:    w_state_next = trap ? BUBBLE : RUN;
      RUN: begin
        if ((w_cause == TRAP) || (w_cause == MISALIGN)) begin
          w_state_next = BUBBLE;
        end
      end
      BUBBLE:  w_state_next = trap ? BUBBLE : RUN;
      default: w_state_next = BOOT;
    endcase
  end

  always_comb begin
    fetch_valid = (r_state == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc            <= START_ADDR;
      r_misaligned    <= 1'b0;
      r_ras_underflow <= 1'b0;
    end else begin
      r_pc            <= w_pc_next;
      r_misaligned    <= (w_cause == MISALIGN);
      r_ras_underflow <= w_underflow;
    end
  end

  assign fetch_addr    = r_pc;
  assign misaligned    = r_misaligned;
  assign ras_underflow = r_ras_underflow;
  assign ras_count     = w_ras_count;

  ras_stack #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAS_DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_addr (w_seq_pc),
    .o_top_addr  (w_ras_top),
    .o_count     (w_ras_count)
  );

endmodule

// File: tb/tb_fetch_pc.sv
// Directed scoreboard bench for fetch_pc: a 32-bit depth-4 instance plus an 8-bit instance for wrap.
module tb_fetch_pc;

  logic        clk;
  logic        reset;

  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        call;
  logic        ret;
  logic        trap;
  logic        misaligned;
  logic        ras_underflow;
  logic [2:0]  ras_count;

  logic [7:0]  d8_addr;
  logic        d8_valid;
  logic        d8_ready;
  logic        d8_branch;
  logic [7:0]  d8_target;
  logic        d8_mis;
  logic        d8_unf;
  logic [1:0]  d8_count;

  typedef struct {
    string       tag;
    bit          d8;
    logic [31:0] addr;
    logic [31:0] valid;
    logic [31:0] mis;
    logic [31:0] unf;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_pc #(
    .ADDR_WIDTH  (32),
    .START_ADDR  (32'h0),
    .INSTR_BYTES (4),
    .TRAP_VECTOR (32'h100),
    .RAS_DEPTH   (4)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_addr    (fetch_addr),
    .fetch_valid   (fetch_valid),
    .fetch_ready   (fetch_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .call          (call),
    .ret           (ret),
    .trap          (trap),
    .misaligned    (misaligned),
    .ras_underflow (ras_underflow),
    .ras_count     (ras_count)
  );

  fetch_pc #(
    .ADDR_WIDTH  (8),
    .START_ADDR  (8'h0),
    .INSTR_BYTES (4),
    .TRAP_VECTOR (8'h80),
    .RAS_DEPTH   (2)
  ) u_dut8 (
    .clk           (clk),
    .reset         (reset),
    .fetch_addr    (d8_addr),
    .fetch_valid   (d8_valid),
    .fetch_ready   (d8_ready),
    .branch_taken  (d8_branch),
    .branch_target (d8_target),
    .call          (1'b0),
    .ret           (1'b0),
    .trap          (1'b0),
    .misaligned    (d8_mis),
    .ras_underflow (d8_unf),
    .ras_count     (d8_count)
  );

  task automatic cmp(input string tag, input string fld, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, got, want);
    end
  endtask

  task automatic exp_m(input string tag, input logic [31:0] a, input logic [31:0] v,
                       input logic [31:0] m, input logic [31:0] u, input logic [31:0] c);
    exp_t e;
    e.tag = tag; e.d8 = 1'b0; e.addr = a; e.valid = v; e.mis = m; e.unf = u; e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic exp_8(input string tag, input logic [31:0] a, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.d8 = 1'b1; e.addr = a; e.valid = v; e.mis = '0; e.unf = '0; e.cnt = '0;
    sb.push_back(e);
  endtask

  task automatic check(input exp_t e);
    if (!e.d8) begin
      cmp(e.tag, "addr",  fetch_addr,             e.addr);
      cmp(e.tag, "valid", 32'(fetch_valid),       e.valid);
      cmp(e.tag, "mis",   32'(misaligned),        e.mis);
      cmp(e.tag, "unf",   32'(ras_underflow),     e.unf);
      cmp(e.tag, "cnt",   32'(ras_count),         e.cnt);
    end else begin
      cmp(e.tag, "addr",  32'(d8_addr),           e.addr);
      cmp(e.tag, "valid", 32'(d8_valid),          e.valid);
      cmp(e.tag, "mis",   32'(d8_mis),            e.mis);
      cmp(e.tag, "unf",   32'(d8_unf),            e.unf);
      cmp(e.tag, "cnt",   32'(d8_count),          e.cnt);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e);
    end
  endtask

  task automatic drive(input logic rdy, input logic br, input logic [31:0] tgt,
                       input logic cl, input logic rt, input logic tr);
    fetch_ready   = rdy;
    branch_taken  = br;
    branch_target = tgt;
    call          = cl;
    ret           = rt;
    trap          = tr;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    d8_ready = 1'b0; d8_branch = 1'b0; d8_target = 8'h0;
    @(negedge clk);

    exp_m("reset", 32'h0, 0, 0, 0, 0); exp_8("reset8", 32'h0, 0); step();
    reset = 1'b0;
    exp_m("boot_to_run", 32'h0, 1, 0, 0, 0); step();
    exp_m("seq4",  32'h4,  1, 0, 0, 0); step();
    exp_m("seq8",  32'h8,  1, 0, 0, 0); step();
    exp_m("seq12", 32'hC,  1, 0, 0, 0); step();
    exp_m("seq16", 32'h10, 1, 0, 0, 0); step();

    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_m("stall", 32'h10, 1, 0, 0, 0); step();
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    exp_m("resume", 32'h14, 1, 0, 0, 0); step();

    drive(1'b1, 1'b1, 32'h42, 1'b0, 1'b0, 1'b0);
    exp_m("misalign", 32'h100, 0, 1, 0, 0); step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    exp_m("bubble_exit", 32'h100, 1, 0, 0, 0); step();
    drive(1'b1, 1'b1, 32'h42, 1'b0, 1'b0, 1'b1);
    exp_m("trap_over_mis", 32'h100, 0, 0, 0, 0); step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    exp_m("trap_exit", 32'h100, 1, 0, 0, 0); step();

    drive(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    exp_m("branch_noready", 32'h20, 1, 0, 0, 0); step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    exp_m("trap", 32'h100, 0, 0, 0, 0); step();
    drive(1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
    exp_m("bubble_ignores_br", 32'h100, 1, 0, 0, 0); step();
    drive(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    exp_m("br20", 32'h20, 1, 0, 0, 0); step();

    drive(1'b1, 1'b1, 32'h30, 1'b1, 1'b0, 1'b0);
    exp_m("call20_br", 32'h30, 1, 0, 0, 1); step();
    drive(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
    exp_m("call30_br", 32'h40, 1, 0, 0, 2); step();
    drive(1'b1, 1'b1, 32'h50, 1'b1, 1'b0, 1'b0);
    exp_m("call40_br", 32'h50, 1, 0, 0, 3); step();
    drive(1'b1, 1'b1, 32'h60, 1'b1, 1'b0, 1'b0);
    exp_m("call50_br", 32'h60, 1, 0, 0, 4); step();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    exp_m("call60_sat", 32'h64, 1, 0, 0, 4); step();

    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    exp_m("ret1", 32'h64, 1, 0, 0, 3); step();
    exp_m("ret2", 32'h54, 1, 0, 0, 2); step();
    exp_m("ret3", 32'h44, 1, 0, 0, 1); step();
    exp_m("ret4", 32'h34, 1, 0, 0, 0); step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    exp_m("ret5_underflow", 32'h38, 1, 0, 1, 0); step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    exp_m("underflow_clears", 32'h3C, 1, 0, 0, 0); step();

    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    exp_m("call3c", 32'h40, 1, 0, 0, 1); step();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    exp_m("call_ret_replace", 32'h40, 1, 0, 0, 1); step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    exp_m("ret_replaced", 32'h44, 1, 0, 0, 0); step();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    exp_m("call_ret_empty", 32'h48, 1, 0, 1, 1); step();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    exp_m("call48", 32'h4C, 1, 0, 0, 2); step();
    exp_m("call4c", 32'h50, 1, 0, 0, 3); step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    exp_m("trap_cnt3", 32'h100, 0, 0, 0, 3); step();

    reset = 1'b1;
    drive(1'b1, 1'b1, 32'h20, 1'b1, 1'b1, 1'b1);
    exp_m("reset_in_bubble", 32'h0, 0, 0, 0, 0); exp_8("reset8_b", 32'h0, 0); step();
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    exp_m("post_reset_run", 32'h0, 1, 0, 0, 0); exp_8("run8", 32'h0, 1); step();

    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    d8_branch = 1'b1; d8_target = 8'hFC;
    exp_8("br_fc", 32'hFC, 1); step();
    d8_branch = 1'b0; d8_ready = 1'b1;
    exp_8("wrap", 32'h00, 1); step();
    exp_8("wrap_next", 32'h04, 1); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the fetch address width in bits.
REQ-002 Parameter START_ADDR, default 0, SHALL set the address loaded on reset.
REQ-003 Parameter INSTR_BYTES, default 4, SHALL set the sequential increment; power of two.
REQ-004 Parameter TRAP_VECTOR, default 'h100, SHALL set the trap redirect address.
REQ-005 Parameter RAS_DEPTH, default 4, SHALL set the return-address-stack entry count; power of two, >=2.
REQ-006 Port list, one per line (name, direction, width, meaning); clock and reset SHALL be first:
  clk  in  1  sole clock; all state updates on posedge.
  reset  in  1  synchronous, active-high.
  fetch_addr  out  ADDR_WIDTH  current fetch PC.
  fetch_valid  out  1  fetch_addr valid this cycle.
  fetch_ready  in  1  instruction memory accepts fetch_addr.
  branch_taken  in  1  redirect request.
  branch_target  in  ADDR_WIDTH  redirect address.
  call  in  1  push fetch_addr+INSTR_BYTES onto RAS.
  ret  in  1  redirect to popped RAS top.
  trap  in  1  external trap request.
  misaligned  out  1  one-cycle pulse: misaligned redirect target.
  ras_underflow  out  1  one-cycle pulse: ret with RAS empty.
  ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.

Function
REQ-007 FSM states SHALL be BOOT, RUN, BUBBLE; BOOT entered on reset, BOOT->RUN after one cycle; BUBBLE->RUN after one cycle.
REQ-008 fetch_valid SHALL be 1 only in RUN.
REQ-009 In RUN, a fetch is accepted when fetch_valid && fetch_ready; PC SHALL then advance by INSTR_BYTES, modulo 2^ADDR_WIDTH (wrap, no flag).
REQ-010 Without acceptance and without redirect, fetch_addr SHALL hold (stall).
REQ-011 Redirects SHALL take effect next cycle regardless of fetch_ready, priority trap > misaligned branch > branch_taken > ret > sequential.
REQ-012 trap SHALL load TRAP_VECTOR and enter BUBBLE.
REQ-013 branch_taken with branch_target low log2(INSTR_BYTES) bits nonzero SHALL load TRAP_VECTOR, pulse misaligned, enter BUBBLE.
REQ-014 Aligned branch_taken SHALL load branch_target, remain RUN.
REQ-015 ret with ras_count>0 SHALL load the top entry and pop it; with ras_count==0 SHALL pulse ras_underflow and advance sequentially if accepted.
REQ-016 call SHALL be honoured only with an accepted fetch; push SHALL occur even when a branch redirects the same cycle.
REQ-017 Push at ras_count==RAS_DEPTH SHALL overwrite the oldest entry; ras_count SHALL saturate.
REQ-018 call and ret together SHALL replace the top entry (pop then push), ras_count unchanged; with empty RAS, push only plus ras_underflow.
REQ-019 Redirect inputs in BOOT or BUBBLE SHALL be ignored except trap, which restarts BUBBLE.

Reset
REQ-020 reset SHALL set fetch_addr=START_ADDR, state BOOT, fetch_valid=0, ras_count=0, misaligned=0, ras_underflow=0.
REQ-021 reset SHALL override all other inputs in the same cycle, including mid-stall and mid-BUBBLE.
REQ-022 RAS entry contents need no reset.

Structure
REQ-023 Package fetch_pkg SHALL hold the FSM state enum and a redirect-cause enum (NONE, TRAP, MISALIGN, BRANCH, RET).
REQ-024 RAS SHALL be a sub-module ras_stack (circular buffer, top pointer, count), parameterised by ADDR_WIDTH and RAS_DEPTH.

Verification
REQ-025 Reset then fetch_ready=1 for 4 cycles -> fetch_valid=0 first cycle, then fetch_addr 0,4,8,12.
REQ-026 fetch_ready=0 three cycles at 0x10 -> fetch_addr holds 0x10; ready=1 -> 0x14.
REQ-027 branch_taken=1, target 0x42 -> misaligned pulse, fetch_addr=0x100, fetch_valid=0 one cycle; same-cycle trap -> misaligned stays 0.
REQ-028 call at 0x20, 0x30, 0x40, 0x50, 0x60 (depth 4), five rets -> targets 0x64,0x54,0x44,0x34, fifth pulses ras_underflow.
REQ-029 ADDR_WIDTH=8, PC=0xFC, accepted fetch -> fetch_addr 0x00.
REQ-030 reset asserted during BUBBLE with ras_count=3 -> next cycle fetch_addr=START_ADDR, ras_count=0, state BOOT.
